lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Data-memory responder for the LC-3 pipeline, sitting on the far side of the stage-4 memory port (`memapply`/`memtype`/`memaddr`/`memdatawr`/`memdata`). It services one load or store at a time with a configurable RAM latency and raises a stall while a request is outstanding. It also implements the LC-3 memory-mapped device registers: KBSR/KBDR (keyboard), DSR/DDR (display) and MCR (machine control).

## Interface
- `DEPTH_LOG2`, 12: log2 of backing RAM depth in 16-bit words.
- `LATENCY`, 2: cycles from RAM request acceptance to data valid; legal range is 1 or more.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `memapply` in 1: request valid; held until the cycle after `mem_ready`.
- `memtype` in 1: 0 = read (load), 1 = write (store).
- `memaddr` in 16: word address.
- `memdatawr` in 16: store data.
- `memdata` out 16: load data; valid while `mem_ready` = 1 and held until the next completion.
- `mem_ready` out 1: registered one-cycle completion pulse.
- `mem_stall` out 1: combinational `memapply & ~mem_ready`, feeds the pipeline stall.
- `kbd_valid` in 1, `kbd_data` in 8, `kbd_ready` out 1: keyboard push handshake.
- `disp_valid` out 1, `disp_data` out 8, `disp_ready` in 1: display pop handshake.
- `run` out 1: MCR[15]; 0 halts the processor clock enable.

## Operation
- **Address decode.**
  - Below xFE00: RAM. Index is `memaddr[DEPTH_LOG2-1:0]`, so addresses alias.
  - xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR, xFFFE MCR.
  - Any other address at or above xFE00 reads as x0000; writes to it are ignored.
- **FSM.**
  - IDLE: `memapply` = 1 on a RAM address moves to WAIT and loads `cnt = LATENCY-1`. On an I/O address it performs the access and moves to DONE.
  - WAIT: `cnt` decrements each cycle. At `cnt` = 0 the RAM access is performed (write committed, or read data captured into `memdata`) and the FSM moves to DONE.
  - DONE: `mem_ready` = 1 for this cycle only; next state is IDLE unconditionally.
- **Keyboard.**
  - `kbd_ready = ~kbd_full`. A transfer with `kbd_valid & kbd_ready` latches `kbd_data` and sets `kbd_full`.
  - KBSR read returns `{kbd_full, 15'b0}`.
  - KBDR read returns `{8'b0, char}` and clears `kbd_full`.
  - Writes to KBSR/KBDR are ignored.
- **Display.**
  - DSR read returns `{~disp_valid, 15'b0}`.
  - DDR write with `disp_valid` = 0 latches `memdatawr[7:0]` into `disp_data` and sets `disp_valid`. A DDR write while `disp_valid` = 1 is dropped.
  - `disp_valid` clears on `disp_valid & disp_ready`.
- **MCR.** Read returns `{run, 15'b0}`. Write sets `run = memdatawr[15]`.
- **Simultaneous events.**
  - KBDR read in the same cycle as a keyboard transfer: the read returns the old character, the new character is stored, `kbd_full` stays 1.
  - DDR write in the same cycle as the display handshake completing: the new character is accepted.

## Timing
- Reset values: `memdata` = x0000, `mem_ready` = 0, FSM = IDLE, `cnt` = 0, `kbd_full` = 0, `kbd_ready` = 1, `disp_valid` = 0, `disp_data` = x00, `run` = 1. RAM contents are not reset.
- RAM access latency: request sampled at edge N; `mem_ready` high after edge N+LATENCY+1.
- I/O access latency: request sampled at edge N; `mem_ready` high after edge N+1.
- The requester changes or drops its request on the negedge following `mem_ready`. A request is accepted only in IDLE, so one held across DONE is never serviced twice.
- Reset during WAIT aborts the access: no RAM write occurs and `mem_ready` does not pulse.
- `memaddr`, `memtype` and `memdatawr` must stay stable from acceptance to `mem_ready`. The responder registers only the RAM index and the type.

## Structure
- Shared package `lc3_mem_pkg`: the I/O address constants (KBSR, KBDR, DSR, DDR, MCR, IO_BASE) and the FSM state encoding.
- Sub-module `lc3_sync_ram`: single-port, synchronous-write, registered-read, `DEPTH_LOG2` × 16. The responder owns all latency counting.

## Test plan
- **RAM store then load.** LATENCY = 2. Write x1234 to x3000, then read x3000. Required: `memdata` = x1234; each `mem_ready` pulse comes 3 cycles after acceptance; `mem_stall` stays high until each pulse.
- **RAM aliasing.** DEPTH_LOG2 = 12. Write xBEEF to x0005, read x1005. Required: `memdata` = xBEEF.
- **Keyboard path.**
  - Push 'A' (x41). Required: KBSR reads x8000 and `kbd_ready` = 0.
  - KBDR read returns x0041. A following KBSR read returns x0000.
  - A KBDR read in the same cycle as a push of 'B' returns x0041; KBSR then reads x8000.
- **Display path.**
  - DDR write x0048 with `disp_ready` = 0. Required: `disp_valid` = 1, `disp_data` = x48, DSR reads x0000.
  - A second DDR write is dropped. After one cycle of `disp_ready`, DSR reads x8000.
- **MCR halt and unmapped space.** MCR write x0000 → `run` = 0 one cycle after `mem_ready`. A read of xFE10 returns x0000.
- **Reset mid-operation.** Assert reset during WAIT of a write of x5555 to x3001. Required: all outputs return to their reset values; a later read of x3001 returns the prior contents.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
// Shared definitions for the LC-3 data-memory responder: the memory-mapped
// device register addresses, the start of I/O space and the responder FSM
// state encoding.
package lc3_mem_pkg;

    localparam logic [15:0] IO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR    = 16'hFE00;
    localparam logic [15:0] KBDR    = 16'hFE02;
    localparam logic [15:0] DSR     = 16'hFE04;
    localparam logic [15:0] DDR     = 16'hFE06;
    localparam logic [15:0] MCR     = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Everything below the I/O page is backed by RAM.
    function automatic logic is_ram_addr(input logic [15:0] addr);
        return addr < IO_BASE;
    endfunction

endpackage

// File: rtl/lc3_sync_ram.sv
// lc3_sync_ram
// Single-port RAM, (2**DEPTH_LOG2) x 16, synchronous write and registered
// read. The read port samples the address every cycle; the caller decides
// when the registered data is meaningful.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - word index
//   wdata - write data
//   rdata - registered read data (value at addr on the previous edge)
module lc3_sync_ram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // NOTE: the storage array has no reset branch; clearing a whole RAM on
    // reset would turn it into flops. Its contents are simply undefined.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
// Stage-4 data-memory responder for the LC-3 pipeline. Services one load or
// store at a time: RAM accesses take LATENCY cycles in WAIT, memory-mapped
// device registers complete immediately. mem_ready is a registered pulse one
// cycle after the FSM reaches DONE.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   memapply/memtype      - request valid / 0 = load, 1 = store
//   memaddr/memdatawr     - word address / store data
//   memdata               - load data, held until the next load completes
//   mem_ready, mem_stall  - completion pulse, pipeline stall
//   kbd_valid/data/ready  - keyboard push handshake
//   disp_valid/data/ready - display pop handshake
//   run                   - MCR[15], processor clock enable
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memapply,
    input  logic        memtype,
    input  logic [15:0] memaddr,
    input  logic [15:0] memdatawr,
    output logic [15:0] memdata,
    output logic        mem_ready,
    output logic        mem_stall,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        run
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wr_q;
    logic                  accept_ram, accept_io, ram_go;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [15:0]           ram_rdata;
    logic [15:0]           io_rdata;
    logic                  kbd_full;
    logic [7:0]            kbd_char;
    logic                  io_rd, io_wr, kbd_push, kbdr_rd, ddr_wr, disp_pop;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        accept_ram = 1'b0;
        accept_io  = 1'b0;
        ram_go     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memapply) begin
                    if (is_ram_addr(memaddr)) begin
                        accept_ram = 1'b1;
                        state_d    = ST_WAIT;
                    end else begin
                        accept_io = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ram_go  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // In IDLE the RAM sees the live address so its registered read is
    // already valid after the acceptance edge; that keeps LATENCY = 1 exact.
    assign ram_addr = (state_q == ST_IDLE) ? memaddr[DEPTH_LOG2-1:0] : idx_q;

    lc3_sync_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (ram_go & wr_q),
        .addr  (ram_addr),
        .wdata (memdatawr),
        .rdata (ram_rdata)
    );

    always_comb begin
        io_rdata = '0;
        case (memaddr)
            KBSR:    io_rdata = {kbd_full, 15'b0};
            KBDR:    io_rdata = {8'b0, kbd_char};
            DSR:     io_rdata = {~disp_valid, 15'b0};
            MCR:     io_rdata = {run, 15'b0};
            default: io_rdata = '0;
        endcase
    end

    assign io_rd     = accept_io & ~memtype;
    assign io_wr     = accept_io & memtype;
    assign kbd_push  = kbd_valid & ~kbd_full;
    assign kbdr_rd   = io_rd & (memaddr == KBDR);
    assign ddr_wr    = io_wr & (memaddr == DDR);
    assign disp_pop  = disp_valid & disp_ready;
    assign kbd_ready = ~kbd_full;
    assign mem_stall = memapply & ~mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            mem_ready <= 1'b0;
            memdata   <= '0;
        end else begin
            state_q   <= state_d;
            mem_ready <= (state_q == ST_DONE);
            if (accept_ram) begin
                cnt_q <= CNT_W'(LATENCY - 1);
                idx_q <= memaddr[DEPTH_LOG2-1:0];
                wr_q  <= memtype;
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (ram_go && !wr_q) begin
                memdata <= ram_rdata;
            end else if (io_rd) begin
                memdata <= io_rdata;
            end
        end
    end

    // Device registers. A push wins over a KBDR read in the same cycle, and
    // a DDR write is accepted if the slot is empty or draining this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_full   <= 1'b0;
            kbd_char   <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            run        <= 1'b1;
        end else begin
            if (kbd_push) begin
                kbd_full <= 1'b1;
                kbd_char <= kbd_data;
            end else if (kbdr_rd) begin
                kbd_full <= 1'b0;
            end

            if (ddr_wr && (!disp_valid || disp_pop)) begin
                disp_valid <= 1'b1;
                disp_data  <= memdatawr[7:0];
            end else if (disp_pop) begin
                disp_valid <= 1'b0;
            end

            if (io_wr && memaddr == MCR) begin
                run <= memdatawr[15];
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;
    import lc3_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        memapply, memtype;
    logic [15:0] memaddr, memdatawr, memdata;
    logic        mem_ready, mem_stall;
    logic        kbd_valid, kbd_ready;
    logic [7:0]  kbd_data;
    logic        disp_valid, disp_ready;
    logic [7:0]  disp_data;
    logic        run;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lc3_mem_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .memapply   (memapply),
        .memtype    (memtype),
        .memaddr    (memaddr),
        .memdatawr  (memdatawr),
        .memdata    (memdata),
        .mem_ready  (mem_ready),
        .mem_stall  (mem_stall),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .run        (run)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; optional keyboard push / display pop in the acceptance
    // cycle. lat counts edges after the acceptance edge until mem_ready.
    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          input logic push, input logic [7:0] ch, input logic pop,
                          output logic [15:0] rd, output int lat);
        logic stall_ok;
        @(negedge clk);
        memapply   = 1'b1;
        memtype    = wr;
        memaddr    = addr;
        memdatawr  = wd;
        kbd_valid  = push;
        kbd_data   = ch;
        disp_ready = pop;
        lat        = -1;
        stall_ok   = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            kbd_valid  = 1'b0;
            disp_ready = 1'b0;
            if (!mem_ready && mem_stall !== 1'b1) stall_ok = 1'b0;
        end while (!mem_ready && lat < 50);
        if (mem_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no mem_ready for addr %h within 50 cycles", addr);
        end
        if (mem_stall !== 1'b0) stall_ok = 1'b0;
        check("mem_stall_profile", {15'b0, stall_ok}, 16'h0001);
        rd       = memdata;
        memapply = 1'b0;
    endtask

    logic [15:0] rd;
    int          lat;

    initial begin
        vecs[0]  = '{"ram_wr_3000",   1'b1, 16'h3000, 16'h1234, 16'h0000, 3};
        vecs[1]  = '{"ram_rd_3000",   1'b0, 16'h3000, 16'h0000, 16'h1234, 3};
        vecs[2]  = '{"ram_wr_0005",   1'b1, 16'h0005, 16'hBEEF, 16'h0000, 3};
        vecs[3]  = '{"ram_alias_1005",1'b0, 16'h1005, 16'h0000, 16'hBEEF, 3};
        vecs[4]  = '{"ram_wr_fdff",   1'b1, 16'hFDFF, 16'hA5A5, 16'h0000, 3};
        vecs[5]  = '{"ram_alias_0dff",1'b0, 16'h0DFF, 16'h0000, 16'hA5A5, 3};
        vecs[6]  = '{"unmapped_rd",   1'b0, 16'hFE10, 16'h0000, 16'h0000, 1};
        vecs[7]  = '{"unmapped_wr",   1'b1, 16'hFE10, 16'hFFFF, 16'h0000, 1};
        vecs[8]  = '{"unmapped_rd2",  1'b0, 16'hFE10, 16'h0000, 16'h0000, 1};
        vecs[9]  = '{"mcr_rd_reset",  1'b0, MCR,      16'h0000, 16'h8000, 1};
        vecs[10] = '{"dsr_rd_reset",  1'b0, DSR,      16'h0000, 16'h8000, 1};
        vecs[11] = '{"kbsr_rd_empty", 1'b0, KBSR,     16'h0000, 16'h0000, 1};
        vecs[12] = '{"kbsr_wr_ign",   1'b1, KBSR,     16'hFFFF, 16'h0000, 1};
        vecs[13] = '{"kbsr_rd_empty2",1'b0, KBSR,     16'h0000, 16'h0000, 1};

        reset = 1'b0; memapply = 1'b0; memtype = 1'b0; memaddr = '0; memdatawr = '0;
        kbd_valid = 1'b0; kbd_data = '0; disp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_memdata",    memdata, 16'h0000);
        check("rst_mem_ready",  {15'b0, mem_ready}, 16'h0000);
        check("rst_mem_stall",  {15'b0, mem_stall}, 16'h0000);
        check("rst_kbd_ready",  {15'b0, kbd_ready}, 16'h0001);
        check("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check("rst_disp_data",  {8'b0, disp_data}, 16'h0000);
        check("rst_run",        {15'b0, run}, 16'h0001);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wd, 1'b0, 8'h00, 1'b0, rd, lat);
            check({vecs[i].name, "_lat"}, 16'(lat), 16'(vecs[i].exp_lat));
            if (!vecs[i].wr) check({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
        end

        // memdata holds after the pulse until the next load completes.
        access(1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00, 1'b0, rd, lat);
        access(1'b1, 16'h3002, 16'h9999, 1'b0, 8'h00, 1'b0, rd, lat);
        repeat (3) @(negedge clk);
        check("memdata_hold", memdata, 16'h1234);

        // Keyboard path.
        @(negedge clk); kbd_valid = 1'b1; kbd_data = 8'h41;
        @(negedge clk); kbd_valid = 1'b0;
        check("kbd_ready_full", {15'b0, kbd_ready}, 16'h0000);
        access(1'b0, KBSR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("kbsr_full", rd, 16'h8000);
        access(1'b0, KBDR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("kbdr_A", rd, 16'h0041);
        check("kbd_ready_after_rd", {15'b0, kbd_ready}, 16'h0001);
        access(1'b0, KBSR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("kbsr_empty", rd, 16'h0000);
        access(1'b0, KBDR, 16'h0, 1'b1, 8'h42, 1'b0, rd, lat);
        check("kbdr_same_cycle_push", rd, 16'h0041);
        access(1'b0, KBSR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("kbsr_full_after_B", rd, 16'h8000);
        access(1'b0, KBDR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("kbdr_B", rd, 16'h0042);

        // Display path.
        access(1'b1, DDR, 16'h0048, 1'b0, 8'h00, 1'b0, rd, lat);
        check("disp_valid_set", {15'b0, disp_valid}, 16'h0001);
        check("disp_data_H", {8'b0, disp_data}, 16'h0048);
        access(1'b0, DSR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("dsr_busy", rd, 16'h0000);
        access(1'b1, DDR, 16'h0049, 1'b0, 8'h00, 1'b0, rd, lat);
        check("ddr_drop", {8'b0, disp_data}, 16'h0048);
        @(negedge clk); disp_ready = 1'b1;
        @(negedge clk); disp_ready = 1'b0;
        check("disp_valid_clr", {15'b0, disp_valid}, 16'h0000);
        access(1'b0, DSR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("dsr_ready", rd, 16'h8000);
        access(1'b1, DDR, 16'h0050, 1'b0, 8'h00, 1'b0, rd, lat);
        access(1'b1, DDR, 16'h0051, 1'b0, 8'h00, 1'b1, rd, lat);
        check("ddr_wr_with_pop_valid", {15'b0, disp_valid}, 16'h0001);
        check("ddr_wr_with_pop_data", {8'b0, disp_data}, 16'h0051);

        // MCR halt.
        access(1'b1, MCR, 16'h0000, 1'b0, 8'h00, 1'b0, rd, lat);
        @(negedge clk);
        check("mcr_halt_run", {15'b0, run}, 16'h0000);
        access(1'b0, MCR, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
        check("mcr_rd_halted", rd, 16'h0000);

        // Reset during WAIT of a store aborts it.
        access(1'b1, 16'h3001, 16'h7777, 1'b0, 8'h00, 1'b0, rd, lat);
        access(1'b0, 16'h3001, 16'h0000, 1'b0, 8'h00, 1'b0, rd, lat);
        check("pre_rst_rd", rd, 16'h7777);
        @(negedge clk); kbd_valid = 1'b1; kbd_data = 8'h43;
        @(negedge clk); kbd_valid = 1'b0;
        @(negedge clk);
        memapply = 1'b1; memtype = 1'b1; memaddr = 16'h3001; memdatawr = 16'h5555;
        @(negedge clk);
        reset = 1'b0; memapply = 1'b0;
        #1;
        check("mid_rst_memdata",    memdata, 16'h0000);
        check("mid_rst_mem_ready",  {15'b0, mem_ready}, 16'h0000);
        check("mid_rst_kbd_ready",  {15'b0, kbd_ready}, 16'h0001);
        check("mid_rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check("mid_rst_disp_data",  {8'b0, disp_data}, 16'h0000);
        check("mid_rst_run",        {15'b0, run}, 16'h0001);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ready_after_abort", {15'b0, mem_ready}, 16'h0000);
        end
        access(1'b0, 16'h3001, 16'h0000, 1'b0, 8'h00, 1'b0, rd, lat);
        check("post_rst_rd", rd, 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
